blink_gen_multi: RTL and testbench

//   Multi-channel programmable blink / tick generator; parametrised successor of the single 1 Hz divider.

---
 rtl/blink_gen_multi.sv | 108 ++++++++++
 tb/tb_blink_gen_multi.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_gen_multi.sv
// Multi-channel programmable blink / tick generator.
// Each channel divides CLK100MHZ by a loadable half-period and runs in off/on/toggle/pulse mode.
module blink_gen_multi #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 49_999_999
) (
  input  logic               CLK100MHZ,
  input  logic               RST,
  input  logic [NCH-1:0]     EN,
  input  logic [2*NCH-1:0]   MODE,
  input  logic               LOAD,
  input  logic [3:0]         LOAD_CH,
  input  logic [CNT_W-1:0]   LOAD_VAL,
  output logic [NCH-1:0]     OUT,
  output logic [NCH-1:0]     TICK
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_PULSE  = 2'b11
  } mode_t;

  logic [CNT_W-1:0] cnt    [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [CNT_W-1:0] half   [NCH];
  logic [CNT_W-1:0] half_d [NCH];
  mode_t            mode_q [NCH];
  mode_t            mode_d [NCH];
  mode_t            req    [NCH];
  logic [NCH-1:0]   mode_chg;
  logic [NCH-1:0]   load_hit;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   out_d;
  logic [NCH-1:0]   tick_d;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        half[i]   <= CNT_W'(DEFAULT_HALF);
        mode_q[i] <= MODE_OFF;
      end
      OUT  <= '0;
      TICK <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i]    <= cnt_d[i];
        half[i]   <= half_d[i];
        mode_q[i] <= mode_d[i];
      end
      OUT  <= out_d;
      TICK <= tick_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      req[i]      = mode_t'(MODE[2*i +: 2]);
      mode_chg[i] = (req[i] != mode_q[i]);
      load_hit[i] = LOAD && (LOAD_CH == 4'(i));
      wrap[i]     = (cnt[i] == half[i]);

      cnt_d[i]  = cnt[i];
      half_d[i] = half[i];
      mode_d[i] = mode_q[i];
      out_d[i]  = OUT[i];
      tick_d[i] = 1'b0;

      // Load and mode change can coincide: mode takes effect, load owns half/cnt.
      if (mode_chg[i]) begin
        mode_d[i] = req[i];
        cnt_d[i]  = '0;
        out_d[i]  = (req[i] == MODE_ON);
      end
      if (load_hit[i]) begin
        half_d[i] = LOAD_VAL;
        cnt_d[i]  = '0;
      end

      if (!mode_chg[i] && !load_hit[i] && EN[i]) begin
        case (mode_q[i])
          MODE_OFF: begin
            cnt_d[i] = '0;
            out_d[i] = 1'b0;
          end
          MODE_ON: begin
            cnt_d[i] = '0;
            out_d[i] = 1'b1;
          end
          MODE_TOGGLE: begin
            cnt_d[i]  = wrap[i] ? '0 : cnt[i] + CNT_W'(1);
            tick_d[i] = wrap[i];
            out_d[i]  = OUT[i] ^ wrap[i];
          end
          default: begin
            cnt_d[i]  = wrap[i] ? '0 : cnt[i] + CNT_W'(1);
            tick_d[i] = wrap[i];
            out_d[i]  = wrap[i];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_gen_multi.sv
// Directed self-checking bench for blink_gen_multi (NCH=4, DEFAULT_HALF=4).
module tb_blink_gen_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic [7:0]  mode;
  logic        load;
  logic [3:0]  load_ch;
  logic [25:0] load_val;
  logic [3:0]  out;
  logic [3:0]  tick;

  int n_cmp = 0;
  int n_bad = 0;

  blink_gen_multi #(
    .NCH          (4),
    .CNT_W        (26),
    .DEFAULT_HALF (4)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .EN        (en),
    .MODE      (mode),
    .LOAD      (load),
    .LOAD_CH   (load_ch),
    .LOAD_VAL  (load_val),
    .OUT       (out),
    .TICK      (tick)
  );

  always #5 clk = ~clk;

  // Expected toggle-mode output/tick with H=4, j edges after the mode-change edge.
  function automatic logic [3:0] tog_out(input int j);
    return (((j / 5) % 2) == 1) ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic [3:0] tog_tick(input int j);
    return (j > 0 && (j % 5) == 0) ? 4'b1111 : 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    load = 1'b0;
    mode = '0;
    en   = '0;
    #2;
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_out: got %b expected %b", out, 4'b0000);
    end
    n_cmp++;
    if (tick !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_tick: got %b expected %b", tick, 4'b0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_toggle();
    logic [3:0] eo, et;
    do_reset();
    mode = 8'b10_10_10_10;
    en   = 4'b1111;
    for (int j = 0; j <= 20; j++) begin
      step();
      eo = tog_out(j);
      et = tog_tick(j);
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL toggle_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL toggle_tick j=%0d: got %b expected %b", j, tick, et);
      end
    end
  endtask

  task automatic test_pulse_load();
    logic [3:0] eo, et;
    do_reset();
    mode     = 8'b10_10_11_10;
    en       = 4'b1111;
    load     = 1'b1;
    load_ch  = 4'd1;
    load_val = 26'd2;
    for (int j = 0; j <= 10; j++) begin
      step();
      if (j == 0) load = 1'b0;
      eo = tog_out(j);
      et = tog_tick(j);
      eo[1] = (j > 0 && (j % 3) == 0);
      et[1] = (j > 0 && (j % 3) == 0);
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL pulse_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL pulse_tick j=%0d: got %b expected %b", j, tick, et);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [3:0] eo, et;
    do_reset();
    mode = 8'b10_10_10_10;
    en   = 4'b1111;
    for (int j = 0; j <= 14; j++) begin
      step();
      eo = tog_out(j);
      et = tog_tick(j);
      eo[2] = (j >= 12);
      et[2] = (j == 12);
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL freeze_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL freeze_tick j=%0d: got %b expected %b", j, tick, et);
      end
      if (j == 2) en = 4'b1011;
      if (j == 9) en = 4'b1111;
    end
  endtask

  task automatic test_load_zero_bad_ch();
    logic [3:0] eo, et;
    do_reset();
    mode = 8'b10_10_10_10;
    en   = 4'b1111;
    for (int j = 0; j <= 12; j++) begin
      step();
      eo = tog_out(j);
      et = tog_tick(j);
      eo[0] = (j >= 2) && ((j % 2) == 0);
      et[0] = (j >= 2);
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL loadzero_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL loadzero_tick j=%0d: got %b expected %b", j, tick, et);
      end
      if (j == 0) begin
        load     = 1'b1;
        load_ch  = 4'd0;
        load_val = 26'd0;
      end
      if (j == 1) load = 1'b0;
      if (j == 5) begin
        load     = 1'b1;
        load_ch  = 4'd9;
        load_val = 26'd1;
      end
      if (j == 6) load = 1'b0;
    end
  endtask

  task automatic test_mode_change();
    logic [3:0] eo, et;
    do_reset();
    mode = 8'b10_10_10_10;
    en   = 4'b1111;
    for (int j = 0; j <= 8; j++) begin
      step();
      eo = tog_out(j);
      et = tog_tick(j);
      eo[3] = (j == 3);
      et[3] = 1'b0;
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL mode_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL mode_tick j=%0d: got %b expected %b", j, tick, et);
      end
      if (j == 2) mode = 8'b01_10_10_10;
      if (j == 3) mode = 8'b00_10_10_10;
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] eo, et;
    do_reset();
    mode     = 8'b10_10_10_10;
    en       = 4'b1111;
    load     = 1'b1;
    load_ch  = 4'd0;
    load_val = 26'd7;
    for (int j = 0; j <= 5; j++) begin
      step();
      if (j == 0) load = 1'b0;
      eo = tog_out(j);
      et = tog_tick(j);
      eo[0] = 1'b0;
      et[0] = 1'b0;
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL prerst_out j=%0d: got %b expected %b", j, out, eo);
      end
      n_cmp++;
      if (tick !== et) begin
        n_bad++;
        $display("FAIL prerst_tick j=%0d: got %b expected %b", j, tick, et);
      end
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_rst_out: got %b expected %b", out, 4'b0000);
    end
    n_cmp++;
    if (tick !== 4'b0000) begin
      n_bad++;
      $display("FAIL async_rst_tick: got %b expected %b", tick, 4'b0000);
    end
    rst = 1'b0;
    // Channel 0 must be back to half=4, so all four wrap together.
    for (int r = 0; r <= 5; r++) begin
      step();
      eo = (r == 5) ? 4'b1111 : 4'b0000;
      n_cmp++;
      if (out !== eo) begin
        n_bad++;
        $display("FAIL postrst_out r=%0d: got %b expected %b", r, out, eo);
      end
      n_cmp++;
      if (tick !== eo) begin
        n_bad++;
        $display("FAIL postrst_tick r=%0d: got %b expected %b", r, tick, eo);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = '0;
    mode     = '0;
    load     = 1'b0;
    load_ch  = '0;
    load_val = '0;
    test_reset();
    test_toggle();
    test_pulse_load();
    test_enable_freeze();
    test_load_zero_bad_ch();
    test_mode_change();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
